sram22_march_bist: RTL

- Upstream BIST stage that drives one sram22 macro port (clk, we, wmask, addr, din) and checks its registered dout.
- Runs a fixed 6-element March C- sequence over every address with a programmable background pattern P.
- Reports pass/fail and captures the first mismatch (address, element, read data, expected data) for scan-out by the BIST top.

---
 rtl/sram22_march_bist_if.sv | 37 +++
 rtl/sram22_march_bist.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_march_bist_if.sv
// sram22_march_bist_if
//   Bundles the single read/write port of one sram22 macro.
//   master : BIST side, drives we/wmask/addr/din and receives dout.
//   slave  : SRAM side, receives the command and returns registered dout.
//   Signals:
//     sram_we    1            write enable (1 = write, 0 = read)
//     sram_wmask WMASK_WIDTH  byte write mask
//     sram_addr  ADDR_WIDTH   word address
//     sram_din   DATA_WIDTH   write data
//     sram_dout  DATA_WIDTH   read data, valid the cycle after a read is sampled
interface sram22_march_bist_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 4
);
  logic                   sram_we;
  logic [WMASK_WIDTH-1:0] sram_wmask;
  logic [ADDR_WIDTH-1:0]  sram_addr;
  logic [DATA_WIDTH-1:0]  sram_din;
  logic [DATA_WIDTH-1:0]  sram_dout;

  modport master (
    output sram_we,
    output sram_wmask,
    output sram_addr,
    output sram_din,
    input  sram_dout
  );

  modport slave (
    input  sram_we,
    input  sram_wmask,
    input  sram_addr,
    input  sram_din,
    output sram_dout
  );
endinterface

// File: rtl/sram22_march_bist.sv
// sram22_march_bist
//   March C- BIST engine for one sram22 port. Runs six elements over every
//   address using a background pattern P latched at start, compares each read
//   against its expected word two edges after issue, and records the first
//   mismatch.
//   Ports:
//     clk           clock (also clocks the SRAM)
//     rstb          synchronous active-low reset
//     start         begin a test; honoured only in IDLE or DONE
//     pattern       background P, latched on an accepted start
//     sram          SRAM command/response bundle (master side)
//     busy          test in progress (first op through final compare)
//     done          test finished; held until the next accepted start
//     fail          a mismatch was seen; meaningful when done=1
//     fail_addr     address of the first mismatch
//     fail_element  March element (0-5) of the first mismatch
//     fail_data     dout returned at the first mismatch
//     fail_expected word that was expected at the first mismatch
module sram22_march_bist #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int WMASK_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] pattern,
  sram22_march_bist_if.master   sram,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [DATA_WIDTH-1:0] fail_expected
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // Elements 3..5 walk the array downwards.
  function automatic logic elem_down(input logic [2:0] e);
    return (e >= 3'd3);
  endfunction

  function automatic logic elem_has_read(input logic [2:0] e);
    return (e != 3'd0);
  endfunction

  function automatic logic elem_has_write(input logic [2:0] e);
    return (e != 3'd5);
  endfunction

  // E2/E4 read ~P; E1/E3 write ~P.
  function automatic logic read_inv(input logic [2:0] e);
    return (e == 3'd2) || (e == 3'd4);
  endfunction

  function automatic logic write_inv(input logic [2:0] e);
    return (e == 3'd1) || (e == 3'd3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] apply_bg(input logic [DATA_WIDTH-1:0] p,
                                                     input logic inv);
    return inv ? ~p : p;
  endfunction

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  pat_q, pat_d;
  logic [2:0]             elem_q, elem_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   wr_q, wr_d;
  logic                   last_q, last_d;

  logic                   sram_we_q, sram_we_d;
  logic [WMASK_WIDTH-1:0] sram_wmask_q, sram_wmask_d;
  logic [ADDR_WIDTH-1:0]  sram_addr_q, sram_addr_d;
  logic [DATA_WIDTH-1:0]  sram_din_q, sram_din_d;

  logic                   rd_vld_p0_q, rd_vld_p0_d;
  logic [2:0]             rd_elem_p0_q, rd_elem_p0_d;
  logic [DATA_WIDTH-1:0]  rd_exp_p0_q, rd_exp_p0_d;

  logic                   rd_vld_p1_q, rd_vld_p1_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_p1_q, rd_addr_p1_d;
  logic [2:0]             rd_elem_p1_q, rd_elem_p1_d;
  logic [DATA_WIDTH-1:0]  rd_exp_p1_q, rd_exp_p1_d;

  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic [ADDR_WIDTH-1:0]  fail_addr_q, fail_addr_d;
  logic [2:0]             fail_element_q, fail_element_d;
  logic [DATA_WIDTH-1:0]  fail_data_q, fail_data_d;
  logic [DATA_WIDTH-1:0]  fail_expected_q, fail_expected_d;

  logic                   accept;
  logic                   active;
  logic                   mismatch;
  logic                   issue;

  logic [2:0]             cur_elem;
  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic                   cur_wr;
  logic [DATA_WIDTH-1:0]  cur_pat;
  logic                   cur_last;
  logic [2:0]             nxt_elem;
  logic [ADDR_WIDTH-1:0]  nxt_addr;
  logic                   nxt_wr;

  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign mismatch = active && rd_vld_p1_q && (sram.sram_dout != rd_exp_p1_q);
  assign issue    = accept || ((state_q == S_RUN) && !last_q && !mismatch);

  // Sequencer: an accepted start issues E0/addr 0 directly from the input
  // pattern; in RUN the cursor registers hold the op to issue next.
  always_comb begin
    cur_elem = elem_q;
    cur_addr = addr_q;
    cur_wr   = wr_q;
    cur_pat  = pat_q;
    if (accept) begin
      cur_elem = 3'd0;
      cur_addr = '0;
      cur_wr   = 1'b1;
      cur_pat  = pattern;
    end
    cur_last = (cur_elem == 3'd5) && (cur_addr == '0);

    nxt_elem = cur_elem;
    nxt_addr = cur_addr;
    nxt_wr   = cur_wr;
    if (!cur_wr && elem_has_write(cur_elem)) begin
      nxt_wr = 1'b1;
    end else if (cur_addr == (elem_down(cur_elem) ? '0 : ADDR_LAST)) begin
      // Element boundary: load the next element's starting address rather
      // than letting the counter wrap.
      nxt_elem = cur_elem + 3'd1;
      nxt_addr = elem_down(nxt_elem) ? ADDR_LAST : '0;
      nxt_wr   = 1'b0;
    end else begin
      nxt_addr = elem_down(cur_elem) ? (cur_addr - ADDR_ONE) : (cur_addr + ADDR_ONE);
      nxt_wr   = !elem_has_read(cur_elem);
    end
  end

  always_comb begin
    state_d         = state_q;
    pat_d           = pat_q;
    elem_d          = elem_q;
    addr_d          = addr_q;
    wr_d            = wr_q;
    last_d          = 1'b0;
    sram_we_d       = 1'b0;
    sram_wmask_d    = '0;
    sram_addr_d     = '0;
    sram_din_d      = '0;
    rd_vld_p0_d     = 1'b0;
    rd_elem_p0_d    = rd_elem_p0_q;
    rd_exp_p0_d     = rd_exp_p0_q;
    rd_vld_p1_d     = active && rd_vld_p0_q && !mismatch;
    rd_addr_p1_d    = sram_addr_q;
    rd_elem_p1_d    = rd_elem_p0_q;
    rd_exp_p1_d     = rd_exp_p0_q;
    fail_d          = fail_q;
    fail_addr_d     = fail_addr_q;
    fail_element_d  = fail_element_q;
    fail_data_d     = fail_data_q;
    fail_expected_d = fail_expected_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d         = S_RUN;
          pat_d           = pattern;
          fail_d          = 1'b0;
          fail_addr_d     = '0;
          fail_element_d  = '0;
          fail_data_d     = '0;
          fail_expected_d = '0;
        end
      end
      S_RUN: begin
        if (mismatch)    state_d = S_DONE;
        else if (last_q) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    // Stage p0: issue one op and tag reads with their expected word.
    if (issue) begin
      sram_we_d    = cur_wr;
      sram_wmask_d = cur_wr ? {WMASK_WIDTH{1'b1}} : '0;
      sram_addr_d  = cur_addr;
      sram_din_d   = cur_wr ? apply_bg(cur_pat, write_inv(cur_elem)) : '0;
      rd_vld_p0_d  = !cur_wr;
      rd_elem_p0_d = cur_elem;
      rd_exp_p0_d  = apply_bg(cur_pat, read_inv(cur_elem));
      last_d       = cur_last;
      elem_d       = nxt_elem;
      addr_d       = nxt_addr;
      wr_d         = nxt_wr;
    end

    // Stage p1 -> compare: dout for the p1 read is on the bus now.
    if (mismatch) begin
      fail_d          = 1'b1;
      fail_addr_d     = rd_addr_p1_q;
      fail_element_d  = rd_elem_p1_q;
      fail_data_d     = sram.sram_dout;
      fail_expected_d = rd_exp_p1_q;
    end

    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q         <= S_IDLE;
      pat_q           <= '0;
      elem_q          <= '0;
      addr_q          <= '0;
      wr_q            <= 1'b0;
      last_q          <= 1'b0;
      sram_we_q       <= 1'b0;
      sram_wmask_q    <= '0;
      sram_addr_q     <= '0;
      sram_din_q      <= '0;
      rd_vld_p0_q     <= 1'b0;
      rd_elem_p0_q    <= '0;
      rd_exp_p0_q     <= '0;
      rd_vld_p1_q     <= 1'b0;
      rd_addr_p1_q    <= '0;
      rd_elem_p1_q    <= '0;
      rd_exp_p1_q     <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      fail_q          <= 1'b0;
      fail_addr_q     <= '0;
      fail_element_q  <= '0;
      fail_data_q     <= '0;
      fail_expected_q <= '0;
    end else begin
      state_q         <= state_d;
      pat_q           <= pat_d;
      elem_q          <= elem_d;
      addr_q          <= addr_d;
      wr_q            <= wr_d;
      last_q          <= last_d;
      sram_we_q       <= sram_we_d;
      sram_wmask_q    <= sram_wmask_d;
      sram_addr_q     <= sram_addr_d;
      sram_din_q      <= sram_din_d;
      rd_vld_p0_q     <= rd_vld_p0_d;
      rd_elem_p0_q    <= rd_elem_p0_d;
      rd_exp_p0_q     <= rd_exp_p0_d;
      rd_vld_p1_q     <= rd_vld_p1_d;
      rd_addr_p1_q    <= rd_addr_p1_d;
      rd_elem_p1_q    <= rd_elem_p1_d;
      rd_exp_p1_q     <= rd_exp_p1_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      fail_q          <= fail_d;
      fail_addr_q     <= fail_addr_d;
      fail_element_q  <= fail_element_d;
      fail_data_q     <= fail_data_d;
      fail_expected_q <= fail_expected_d;
    end
  end

  assign sram.sram_we    = sram_we_q;
  assign sram.sram_wmask = sram_wmask_q;
  assign sram.sram_addr  = sram_addr_q;
  assign sram.sram_din   = sram_din_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail            = fail_q;
  assign fail_addr       = fail_addr_q;
  assign fail_element    = fail_element_q;
  assign fail_data       = fail_data_q;
  assign fail_expected   = fail_expected_q;

endmodule
